// File: rtl/fetch_stage_if.sv
// fetch_stage_if: handshake and bus signals between the fetch stage and its surroundings
interface fetch_stage_if;
  logic        Stall;
  logic        BranchTaken_D;
  logic [31:0] BranchTarget_D;
  logic        Jump_D;
  logic [31:0] JumpTarget_D;
  logic [31:0] Imem_Addr;
  logic [31:0] Imem_Data;
  logic [31:0] Instr_D;
  logic [31:0] PCPlus4_D;
  logic        Valid_D;
  logic        Halt;
  modport master (
    output Stall, BranchTaken_D, BranchTarget_D, Jump_D, JumpTarget_D, Imem_Data,
    input  Imem_Addr, Instr_D, PCPlus4_D, Valid_D, Halt
  );
  modport slave (
    input  Stall, BranchTaken_D, BranchTarget_D, Jump_D, JumpTarget_D, Imem_Data,
    output Imem_Addr, Instr_D, PCPlus4_D, Valid_D, Halt
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction fetch with IF/ID register, redirect squash and halt drain
// Ports: CLK/RST (sync, active-high); bus.slave carries Stall, branch/jump redirects,
// imem address/data, and the IF/ID outputs Instr_D, PCPlus4_D, Valid_D plus Halt.
module fetch_stage #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD    = 32'hFFFF_FFFF,
  parameter int          DRAIN_CYCLES = 4
) (
  input logic          CLK,
  input logic          RST,
  fetch_stage_if.slave bus
);
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, pc4_q, pc4_d;
  logic        valid_q, valid_d, halt_q, halt_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pc_plus4, target;
  assign pc_plus4 = pc_q + 32'd4;
  // jump has priority over a taken branch; low bits dropped to keep word alignment
  assign target = bus.Jump_D ? {bus.JumpTarget_D[31:2], 2'b00} : {bus.BranchTarget_D[31:2], 2'b00};
  assign bus.Imem_Addr = pc_q;
  assign bus.Instr_D   = instr_q;
  assign bus.PCPlus4_D = pc4_q;
  assign bus.Valid_D   = valid_q;
  assign bus.Halt      = halt_q;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    halt_d  = halt_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: if (!bus.Stall) begin
        if (bus.Jump_D || bus.BranchTaken_D) begin
          pc_d    = target;
          instr_d = '0;
          pc4_d   = '0;
          valid_d = 1'b0;
        end else if (bus.Imem_Data == HALT_WORD) begin
          instr_d = '0;
          pc4_d   = '0;
          valid_d = 1'b0;
          cnt_d   = 4'(DRAIN_CYCLES);
          state_d = DRAIN;
        end else begin
          pc_d    = pc_plus4;
          instr_d = bus.Imem_Data;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
        end
      end
      DRAIN: begin
        instr_d = '0;
        valid_d = 1'b0;
        if (!bus.Stall) begin
          cnt_d   = cnt_q - 4'd1;
          state_d = cnt_q == 4'd1 ? HALTED : DRAIN;
          halt_d  = cnt_q == 4'd1;
        end
      end
      default: ;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      halt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      halt_q  <= halt_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register for the 5-stage MIPS pipeline. It owns the PC, drives the instruction-memory address, and captures fetched words into the decode-stage register. It consumes the load-use Stall from hazard detection and the branch/jump redirects resolved in ID. It also detects the end-of-program word, drains the pipeline and raises Halt.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
HALT_WORD, 32'hFFFF_FFFF, instruction word that terminates fetch
DRAIN_CYCLES, 4, non-stalled cycles after halt detection before Halt asserts (range 1..15)

Ports:
CLK  input  1  clock, rising edge
RST  input  1  synchronous reset, active-high
Stall  input  1  load-use stall from hazard detection; freezes PC and IF/ID
BranchTaken_D  input  1  branch in ID resolved taken
BranchTarget_D  input  32  branch target address
Jump_D  input  1  jump in ID
JumpTarget_D  input  32  jump target address
Imem_Addr  output  32  instruction-memory address, combinational = PC
Imem_Data  input  32  instruction word at Imem_Addr, same-cycle read
Instr_D  output  32  IF/ID instruction register
PCPlus4_D  output  32  IF/ID PC+4 register
Valid_D  output  1  Instr_D holds a real fetched instruction
Halt  output  1  program finished, pipeline drained (registered)

Behaviour:
- One clock (CLK); reset is synchronous and active-high (RST). RST wins over every other input.
- Reset values: PC=RESET_PC, Instr_D=0 (NOP), PCPlus4_D=0, Valid_D=0, Halt=0, state=RUN, drain counter=0.
- Imem_Addr=PC at all times. PC arithmetic is 32-bit modulo 2^32. PC+4 wraps from 32'hFFFF_FFFC to 0.
- Redirect targets have bits [1:0] forced to 0 before loading into PC.
- States: RUN, DRAIN, HALTED.
- RUN: each edge applies the first matching row:
  - 1. Stall=1: PC, Instr_D, PCPlus4_D and Valid_D all hold. Redirect inputs are ignored because the branch operands are not ready.
  - 2. Jump_D=1: PC<=JumpTarget_D, Instr_D<=0, Valid_D<=0, PCPlus4_D<=0. No delay slot; the fetched word is squashed. Jump beats branch if both are high.
  - 3. BranchTaken_D=1: same as row 2 using BranchTarget_D.
  - 4. Imem_Data==HALT_WORD: PC holds, Instr_D<=0, Valid_D<=0, PCPlus4_D<=0, counter<=DRAIN_CYCLES, state<=DRAIN. A halt word on a squashed path never triggers because rows 2 and 3 win.
  - 5. Otherwise: PC<=PC+4, Instr_D<=Imem_Data, PCPlus4_D<=PC+4, Valid_D<=1.
- DRAIN:
  - PC holds. Instr_D=0 and Valid_D=0 are forced every edge. Redirects are ignored.
  - When Stall=0, the counter decrements; when Stall=1, it holds.
  - On the edge where the counter goes 1->0: state<=HALTED and Halt<=1.
- HALTED: all registers frozen, Halt=1. Only RST exits, returning to RUN with the reset values.
- Reset asserted in DRAIN or HALTED: the next edge yields the full reset state and Halt=0 in the same cycle.
- No combinational path from Stall or the redirect inputs to any registered output. Imem_Addr is the only combinational output.

Test Plan:
- Reset then sequential fetch: RST high 2 cycles, imem returns 0x20080001/0x20090002/0x200A0003 at 0/4/8 -> Imem_Addr 0,4,8,12 on successive cycles; Instr_D follows one cycle later with PCPlus4_D 4,8,12; Valid_D goes 0->1.
- Stall hold: Stall=1 for 3 cycles at PC=0x10 -> Imem_Addr stays 0x10; Instr_D and PCPlus4_D=0x10 hold for 3 edges; fetch of 0x10 resumes on release.
- Branch flush: BranchTaken_D=1, BranchTarget_D=0x43 at PC=0x20 -> next PC=0x40; Instr_D=0, Valid_D=0 for one cycle; then the word at 0x40 with PCPlus4_D=0x44.
- Simultaneous Stall+Jump and Jump+Branch:
  - Stall=1, Jump_D=1 (0x100) -> PC unchanged.
  - Stall=0, Jump_D=1 (0x100), BranchTaken_D=1 (0x200) -> PC=0x100.
- Halt drain with stall: HALT_WORD fetched at 0x30, DRAIN_CYCLES=4, Stall=1 for 1 cycle during drain -> PC stays 0x30; Halt rises exactly 5 edges after detection; Valid_D=0 throughout.
- Reset mid-drain and post-halt: RST during DRAIN counter=2 -> next cycle PC=RESET_PC, Halt=0, state RUN. Repeat from HALTED -> same result. BranchTaken_D pulses in HALTED -> no PC change.
